uart_rx_oversampled: RTL and testbench
======================================

UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 16: clk_in cycles per oversample tick, minimum 2.
REQ-002 SHALL have parameter OVERSAMPLE, default 16: ticks per bit, even, minimum 8.
REQ-003 SHALL have parameter DATA_BITS, default 8: data bits per frame, range 5..9.
REQ-004 SHALL have port clk_in  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port rx_in  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port data_out  output  DATA_BITS  last received word, LSB first on the line.
REQ-008 SHALL have port data_valid  output  1  one-cycle pulse when data_out holds a new good word.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-010 SHALL have port parity_err  output  1  one-cycle pulse when parity mismatches; constant 0 without RX_PARITY_EN.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL pass rx_in through a 2-flop synchronizer; all later logic uses the synchronized value rx_s.
REQ-013 SHALL use an internal tick counter 0..BAUD_DIV-1 with a one-cycle tick at BAUD_DIV-1; no derived clocks.
REQ-014 SHALL clear the tick counter and the sample counter when a falling edge of rx_s is detected in IDLE.
REQ-015 SHALL implement the states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-016 IDLE -> START on a falling edge of rx_s.
REQ-017 START: at sample count OVERSAMPLE/2-1, rx_s=0 -> DATA with the sample counter cleared; rx_s=1 -> IDLE (glitch rejected, no output pulse).
REQ-018 DATA: shift rx_s in at sample count OVERSAMPLE-1 (mid-bit), LSB first; after DATA_BITS samples go to PARITY (with RX_PARITY_EN) or STOP.
REQ-019 STOP: at the mid-bit sample, rx_s=1 -> IDLE; rx_s=0 -> WAIT_HIGH.
REQ-020 WAIT_HIGH: remain until rx_s=1, then go to IDLE; a held-low break SHALL produce exactly one frame_err.
REQ-021 SHALL load data_out and pulse the status outputs on the clk_in edge after the stop-bit sample.
REQ-022 Stop bit high and no parity error -> data_valid=1 for 1 cycle.
REQ-023 Stop bit low -> frame_err=1 for 1 cycle, data_valid stays 0, and data_out is still updated.
REQ-024 Parity error and stop bit high -> parity_err=1 for 1 cycle and data_valid stays 0; both errors -> both flags pulse.
REQ-025 Back-to-back frames SHALL be received with zero idle bits between the stop bit and the next start bit.
REQ-026 data_out SHALL hold its value until the next frame completes.

Reset
REQ-027 reset high at a clk_in edge SHALL force state IDLE, clear all counters, set both synchronizer flops to 1, and set data_out=0 and data_valid=frame_err=parity_err=busy=0.
REQ-028 Reset mid-frame SHALL abort the frame with no output pulse; after release, reception starts at the next falling edge.

Configuration
REQ-029 Macro RX_PARITY_EN defined: one even-parity bit follows the data bits (PARITY state) and is checked; a mismatch drives parity_err.
REQ-030 Macro RX_PARITY_EN undefined: no PARITY state, frame = start + DATA_BITS + stop, parity_err tied to 0.

Verification (BAUD_DIV=4, OVERSAMPLE=16, DATA_BITS=8, bit = 64 clk_in cycles)
REQ-031 Send 0xA5 with a good stop bit -> data_out=0xA5, data_valid pulses once, frame_err=0, busy returns to 0.
REQ-032 Drive rx_in low for 20 cycles, then high -> state returns to IDLE, no data_valid or frame_err pulse.
REQ-033 Send 0x3C with stop bit 0, then hold rx_in low 500 cycles -> exactly one frame_err pulse, no data_valid, data_out=0x3C; next frame 0x81 is received correctly after rx_in goes high.
REQ-034 Send 0x00, 0xFF, 0x55 back-to-back with no idle bits -> three data_valid pulses in order with the correct values.
REQ-035 Assert reset at data bit 4 of frame 0x12, then send 0x34 -> no output for 0x12, data_out=0x34 with one data_valid pulse.
REQ-036 With RX_PARITY_EN, send 0x07 with parity bit 0 -> parity_err pulses, no data_valid; with parity bit 1 -> data_valid pulses and data_out=0x07.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - oversampled UART receiver sampling each bit at its centre.
// Define RX_PARITY_EN to receive and check one even-parity bit after the data bits.
module uart_rx_oversampled #(
  parameter int BAUD_DIV   = 16,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);
  localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t               state_q;
  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  logic [TW-1:0]        tick_cnt_q;
  logic [SW-1:0]        samp_cnt_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q, data_q;
  logic                 valid_q, ferr_q, busy_q;
  logic                 tick, fall, half_bit, full_bit;

  assign tick     = (tick_cnt_q == TW'(BAUD_DIV - 1));
  assign fall     = rx_prev_q & ~rx_s_q;
  assign half_bit = tick && (samp_cnt_q == SW'(OVERSAMPLE / 2 - 1));
  assign full_bit = tick && (samp_cnt_q == SW'(OVERSAMPLE - 1));

`ifdef RX_PARITY_EN
  logic par_bit_q, perr_q, par_bad;
  // Even parity: the parity bit must equal the XOR of the data bits.
  assign par_bad    = par_bit_q ^ (^shift_q);
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q    <= IDLE;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      tick_cnt_q <= '0;
      samp_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef RX_PARITY_EN
      par_bit_q  <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      rx_meta_q  <= rx_in;
      rx_s_q     <= rx_meta_q;
      rx_prev_q  <= rx_s_q;
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
      if (tick) samp_cnt_q <= samp_cnt_q + 1'b1;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef RX_PARITY_EN
      perr_q     <= 1'b0;
`endif
      case (state_q)
        IDLE: if (fall) begin
          // Realign the bit timing to the start-bit edge.
          state_q    <= START;
          tick_cnt_q <= '0;
          samp_cnt_q <= '0;
          busy_q     <= 1'b1;
        end
        START: if (half_bit) begin
          samp_cnt_q <= '0;
          bit_cnt_q  <= '0;
          if (rx_s_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= DATA;
          end
        end
        DATA: if (full_bit) begin
          samp_cnt_q <= '0;
          shift_q    <= {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_q  <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
`ifdef RX_PARITY_EN
            state_q <= PARITY;
`else
            state_q <= STOP;
`endif
          end
        end
`ifdef RX_PARITY_EN
        PARITY: if (full_bit) begin
          samp_cnt_q <= '0;
          par_bit_q  <= rx_s_q;
          state_q    <= STOP;
        end
`endif
        STOP: if (full_bit) begin
          samp_cnt_q <= '0;
          data_q     <= shift_q;
          ferr_q     <= ~rx_s_q;
`ifdef RX_PARITY_EN
          perr_q     <= par_bad;
          valid_q    <= rx_s_q & ~par_bad;
`else
          valid_q    <= rx_s_q;
`endif
          if (rx_s_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= WAIT_HIGH;
          end
        end
        // A held-low line is a break: wait it out without reporting again.
        WAIT_HIGH: if (rx_s_q) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - bench for uart_rx_oversampled (BAUD_DIV=4, OVERSAMPLE=16, 8 data bits).
// Frames are sent with a parity bit when RX_PARITY_EN is defined.
module tb_uart_rx_oversampled;
  localparam int BIT = 64;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b1;
  logic       rx_in  = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, frame_err, parity_err, busy;

  uart_rx_oversampled #(.BAUD_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk_in(clk_in), .reset(reset), .rx_in(rx_in), .data_out(data_out),
    .data_valid(data_valid), .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [7:0] data;
    logic       v;
    logic       f;
    logic       p;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic [7:0] exp_data;
    logic       exp_v;
    logic       exp_f;
  } vec_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  always @(negedge clk_in) begin
    if (data_valid || frame_err || parity_err) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {29'b0, data_valid, frame_err, parity_err}, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_data", {24'b0, data_out}, {24'b0, e.data});
        chk("pulse_valid", {31'b0, data_valid}, {31'b0, e.v});
        chk("pulse_frame_err", {31'b0, frame_err}, {31'b0, e.f});
        chk("pulse_parity_err", {31'b0, parity_err}, {31'b0, e.p});
      end
    end
  end

  task automatic send_bit(input logic b, input int cycles);
    rx_in = b;
    repeat (cycles) @(negedge clk_in);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    send_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) send_bit(d[i], BIT);
`ifdef RX_PARITY_EN
    send_bit(par, BIT);
`else
    if (par === 1'bx) $display("parity bit unused");
`endif
    send_bit(stop, BIT);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    repeat (8) @(negedge clk_in);
    chk({name, "_all_pulses_seen"}, exp_q.size(), 0);
  endtask

  vec_t vecs[7];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{data: 8'hA5, stop: 1'b1, gap: 2, exp_data: 8'hA5, exp_v: 1'b1, exp_f: 1'b0};
    vecs[1] = '{data: 8'h00, stop: 1'b1, gap: 2, exp_data: 8'h00, exp_v: 1'b1, exp_f: 1'b0};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, gap: 0, exp_data: 8'hFF, exp_v: 1'b1, exp_f: 1'b0};
    vecs[3] = '{data: 8'h55, stop: 1'b1, gap: 0, exp_data: 8'h55, exp_v: 1'b1, exp_f: 1'b0};
    vecs[4] = '{data: 8'h96, stop: 1'b0, gap: 1, exp_data: 8'h96, exp_v: 1'b0, exp_f: 1'b1};
    vecs[5] = '{data: 8'h69, stop: 1'b1, gap: 1, exp_data: 8'h69, exp_v: 1'b1, exp_f: 1'b0};
    vecs[6] = '{data: 8'h01, stop: 1'b1, gap: 0, exp_data: 8'h01, exp_v: 1'b1, exp_f: 1'b0};

    repeat (5) @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    chk("reset_data_out", {24'b0, data_out}, 32'h0);
    chk("reset_flags", {28'b0, data_valid, frame_err, parity_err, busy}, 32'h0);

    for (int i = 0; i < 7; i++) begin
      send_bit(1'b1, vecs[i].gap * BIT);
      exp_q.push_back('{data: vecs[i].exp_data, v: vecs[i].exp_v, f: vecs[i].exp_f, p: 1'b0});
      send_frame(vecs[i].data, vecs[i].stop, ^vecs[i].data);
      if (i == 0) begin
        chk("busy_after_a5", {31'b0, busy}, 32'h0);
        chk("data_out_a5", {24'b0, data_out}, 32'hA5);
      end
    end
    send_bit(1'b1, 2 * BIT);
    drain("table");
    chk("data_out_hold", {24'b0, data_out}, 32'h01);
    chk("busy_idle_table", {31'b0, busy}, 32'h0);

    // Start-bit glitch: 20 cycles low must be rejected without any pulse.
    send_bit(1'b0, 20);
    send_bit(1'b1, 2 * BIT);
    chk("glitch_busy", {31'b0, busy}, 32'h0);
    chk("glitch_data_kept", {24'b0, data_out}, 32'h01);

    // Break: bad stop bit followed by a long low line reports one frame error.
    exp_q.push_back('{data: 8'h3C, v: 1'b0, f: 1'b1, p: 1'b0});
    send_frame(8'h3C, 1'b0, ^8'h3C);
    send_bit(1'b0, 500);
    chk("break_busy", {31'b0, busy}, 32'h1);
    chk("break_data_out", {24'b0, data_out}, 32'h3C);
    send_bit(1'b1, BIT);
    chk("break_released", {31'b0, busy}, 32'h0);
    exp_q.push_back('{data: 8'h81, v: 1'b1, f: 1'b0, p: 1'b0});
    send_frame(8'h81, 1'b1, ^8'h81);
    send_bit(1'b1, BIT);
    drain("break");
    chk("after_break_data", {24'b0, data_out}, 32'h81);

    // Reset in the middle of data bit 4 of 0x12 aborts that frame.
    send_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) send_bit(((8'h12 >> i) & 8'h1) != 0, BIT);
    send_bit(1'b1, BIT / 2);
    reset = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    chk("reset_mid_busy", {31'b0, busy}, 32'h0);
    chk("reset_mid_data", {24'b0, data_out}, 32'h0);
    send_bit(1'b1, 2 * BIT);
    exp_q.push_back('{data: 8'h34, v: 1'b1, f: 1'b0, p: 1'b0});
    send_frame(8'h34, 1'b1, ^8'h34);
    send_bit(1'b1, BIT);
    drain("reset_mid");
    chk("after_reset_data", {24'b0, data_out}, 32'h34);

`ifdef RX_PARITY_EN
    exp_q.push_back('{data: 8'h07, v: 1'b0, f: 1'b0, p: 1'b1});
    send_frame(8'h07, 1'b1, 1'b0);
    send_bit(1'b1, BIT);
    exp_q.push_back('{data: 8'h07, v: 1'b1, f: 1'b0, p: 1'b0});
    send_frame(8'h07, 1'b1, 1'b1);
    send_bit(1'b1, BIT);
    exp_q.push_back('{data: 8'h0F, v: 1'b0, f: 1'b1, p: 1'b1});
    send_frame(8'h0F, 1'b0, 1'b1);
    send_bit(1'b1, BIT);
    drain("parity");
    chk("parity_data", {24'b0, data_out}, 32'h0F);
`endif

    chk("final_busy", {31'b0, busy}, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
